mem_stage_sram: RTL and testbench

- Memory stage of the 5-stage ARM pipeline. Consumes the EXE/MEM register outputs: ALU result as address, Rm value as store data, and the control bits.
- Performs 32-bit loads/stores over a 16-bit external SRAM as two half-word accesses plus fixed wait cycles.
- Drives `ready` low to freeze the upstream pipeline while an access is in progress.
- Contains the MEM/WB pipeline register feeding the write-back mux.

---
 rtl/mem_stage_sram.sv | 165 ++++++++++++++++
 tb/tb_mem_stage_sram.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_sram.sv
// Memory stage: 32-bit loads/stores over a 16-bit SRAM,
// pipeline freeze while busy, and the MEM/WB register.
module mem_stage_sram #(
    parameter int unsigned BASE_ADDR     = 1024,
    parameter int unsigned ACCESS_CYCLES = 6
) (
    input  logic        clk,
    input  logic        rest,
    input  logic        wb_en_in,
    input  logic        mem_r_en,
    input  logic        mem_w_en,
    input  logic [31:0] alu_res,
    input  logic [31:0] val_rm,
    input  logic [3:0]  dest_in,
    output logic        ready,
    output logic        wb_en_out,
    output logic        mem_r_en_out,
    output logic [31:0] alu_res_out,
    output logic [31:0] mem_data,
    output logic [3:0]  dest_out,
    output logic [17:0] sram_addr,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        WAIT,
        DONE
    } state_t;

    localparam state_t AFTER_HIGH =
        (ACCESS_CYCLES > 3) ? WAIT : DONE;
    localparam logic [15:0] WAIT_LAST =
        16'(ACCESS_CYCLES - 4);

    state_t      state;
    state_t      state_nx;
    logic [15:0] cnt;
    logic [15:0] cnt_nx;
    logic [17:0] addr_q;
    logic [17:0] addr_nx;
    logic [15:0] data_lo;
    logic [15:0] data_hi;
    logic [15:0] lo_nx;
    logic [15:0] hi_nx;
    logic        op;
    logic        rd;
    logic [16:0] woff;
    logic [17:0] lo_addr;
    logic [17:0] hi_addr;

    assign op = mem_r_en | mem_w_en;
    assign rd = mem_r_en & ~mem_w_en;

    // Word offset from the SRAM window base; byte lanes ignored.
    assign woff =
        17'((alu_res[18:0] - 19'(BASE_ADDR)) >> 2);
    assign lo_addr = {woff, 1'b0};
    assign hi_addr = {woff, 1'b1};

    assign ready = ~op | (state == DONE);

    // Next state, bus drive and read-half capture.
    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt;
        addr_nx     = addr_q;
        lo_nx       = data_lo;
        hi_nx       = data_hi;
        sram_addr   = addr_q;
        sram_we_n   = 1'b1;
        sram_dq_oe  = 1'b0;
        sram_dq_out = '0;
        if (!op) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    addr_nx   = lo_addr;
                    sram_addr = lo_addr;
                    if (mem_w_en) begin
                        sram_we_n   = 1'b0;
                        sram_dq_oe  = 1'b1;
                        sram_dq_out = val_rm[15:0];
                    end else begin
                        lo_nx = sram_dq_in;
                    end
                    state_nx = HIGH;
                end
                HIGH: begin
                    addr_nx   = hi_addr;
                    sram_addr = hi_addr;
                    if (mem_w_en) begin
                        sram_we_n   = 1'b0;
                        sram_dq_oe  = 1'b1;
                        sram_dq_out = val_rm[31:16];
                    end else begin
                        hi_nx = sram_dq_in;
                    end
                    cnt_nx   = '0;
                    state_nx = AFTER_HIGH;
                end
                WAIT: begin
                    cnt_nx = cnt + 16'd1;
                    if (cnt == WAIT_LAST) begin
                        state_nx = DONE;
                    end
                end
                DONE: begin
                    state_nx = IDLE;
                end
            endcase
        end
        if (!rest) begin
            sram_addr   = '0;
            sram_we_n   = 1'b1;
            sram_dq_oe  = 1'b0;
            sram_dq_out = '0;
        end
    end

    // FSM, held bus address and read halves.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state   <= IDLE;
            cnt     <= '0;
            addr_q  <= '0;
            data_lo <= '0;
            data_hi <= '0;
        end else begin
            state   <= state_nx;
            cnt     <= cnt_nx;
            addr_q  <= addr_nx;
            data_lo <= lo_nx;
            data_hi <= hi_nx;
        end
    end

    // MEM/WB register; DONE always trails HIGH by an edge,
    // so data_hi is already settled when it is loaded.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
            alu_res_out  <= '0;
            mem_data     <= '0;
            dest_out     <= '0;
        end else if (ready) begin
            wb_en_out    <= wb_en_in;
            mem_r_en_out <= rd;
            alu_res_out  <= alu_res;
            mem_data     <= {data_hi, data_lo};
            dest_out     <= dest_in;
        end else begin
            wb_en_out    <= 1'b0;
            mem_r_en_out <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage_sram.sv
// Randomised bench for mem_stage_sram against a cycle
// model built from access phases and a shadow SRAM.
module tb_mem_stage_sram;

    localparam int BASE = 1024;
    localparam int AC   = 6;

    logic        clk = 1'b0;
    logic        rest;
    logic        wb_en_in;
    logic        mem_r_en;
    logic        mem_w_en;
    logic [31:0] alu_res;
    logic [31:0] val_rm;
    logic [3:0]  dest_in;
    logic        ready;
    logic        wb_en_out;
    logic        mem_r_en_out;
    logic [31:0] alu_res_out;
    logic [31:0] mem_data;
    logic [3:0]  dest_out;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;

    logic        t_wb;
    logic        t_r;
    logic        t_w;
    logic [31:0] t_alu;
    logic [31:0] t_val;
    logic [3:0]  t_dest;
    logic        t_ready;
    logic        t_wb_out;
    logic        t_mr_out;
    logic [31:0] t_alu_out;
    logic [31:0] t_data;
    logic [3:0]  t_dest_out;
    logic [17:0] t_addr;
    logic [15:0] t_dq_out;
    logic        t_oe;
    logic [15:0] t_dq_in;
    logic        t_we_n;

    logic [15:0] dev  [0:1023];
    logic [15:0] refm [0:1023];

    always #5 clk = ~clk;

    assign sram_dq_in = dev[sram_addr[9:0]];
    assign t_dq_in    = dev[t_addr[9:0]];

    mem_stage_sram #(
        .BASE_ADDR(BASE),
        .ACCESS_CYCLES(AC)
    ) dut (
        .clk(clk), .rest(rest),
        .wb_en_in(wb_en_in), .mem_r_en(mem_r_en),
        .mem_w_en(mem_w_en), .alu_res(alu_res),
        .val_rm(val_rm), .dest_in(dest_in),
        .ready(ready), .wb_en_out(wb_en_out),
        .mem_r_en_out(mem_r_en_out),
        .alu_res_out(alu_res_out),
        .mem_data(mem_data), .dest_out(dest_out),
        .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in),
        .sram_we_n(sram_we_n)
    );

    mem_stage_sram #(
        .BASE_ADDR(BASE),
        .ACCESS_CYCLES(3)
    ) dut3 (
        .clk(clk), .rest(rest),
        .wb_en_in(t_wb), .mem_r_en(t_r),
        .mem_w_en(t_w), .alu_res(t_alu),
        .val_rm(t_val), .dest_in(t_dest),
        .ready(t_ready), .wb_en_out(t_wb_out),
        .mem_r_en_out(t_mr_out),
        .alu_res_out(t_alu_out),
        .mem_data(t_data), .dest_out(t_dest_out),
        .sram_addr(t_addr),
        .sram_dq_out(t_dq_out),
        .sram_dq_oe(t_oe),
        .sram_dq_in(t_dq_in),
        .sram_we_n(t_we_n)
    );

    int n_checks = 0;
    int n_fail   = 0;

    int          k;
    logic        m_ready;
    logic [17:0] m_addr_last;
    logic [15:0] m_lo;
    logic [15:0] m_hi;
    logic        m_wb;
    logic        m_mr;
    logic [31:0] m_alu;
    logic [31:0] m_data;
    logic [3:0]  m_dest;

    logic        s_ready;
    logic [17:0] s_addr;
    logic [15:0] s_dq;
    logic        s_we;
    logic        s3_ready;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic logic [17:0] lo_of(
        input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return {off[18:2], 1'b0};
    endfunction

    task automatic model_reset();
        k           = 0;
        m_addr_last = '0;
        m_lo        = '0;
        m_hi        = '0;
        m_wb        = 1'b0;
        m_mr        = 1'b0;
        m_alu       = '0;
        m_data      = '0;
        m_dest      = '0;
    endtask

    task automatic set_in(input logic wb,
                          input logic r,
                          input logic w,
                          input logic [31:0] a,
                          input logic [31:0] v,
                          input logic [3:0] d);
        wb_en_in = wb;
        mem_r_en = r;
        mem_w_en = w;
        alu_res  = a;
        val_rm   = v;
        dest_in  = d;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_wb"}, wb_en_out, 0);
        chk({tag, "_mr"}, mem_r_en_out, 0);
        chk({tag, "_alu"}, alu_res_out, 0);
        chk({tag, "_data"}, mem_data, 0);
        chk({tag, "_dest"}, dest_out, 0);
        chk({tag, "_addr"}, sram_addr, 0);
        chk({tag, "_dq"}, sram_dq_out, 0);
        chk({tag, "_oe"}, sram_dq_oe, 0);
        chk({tag, "_we_n"}, sram_we_n, 1);
        chk({tag, "_ready"}, ready,
            !(mem_r_en | mem_w_en));
    endtask

    // One clock: bus/ready checked mid-low phase, MEM/WB
    // checked just after the rising edge.
    task automatic step();
        logic        op;
        logic        w;
        logic        rd;
        logic [17:0] lo;
        logic [17:0] hi;
        logic [17:0] e_addr;
        logic        e_we;
        logic        e_oe;
        logic [15:0] e_dq;
        @(negedge clk);
        #1;
        op      = mem_r_en | mem_w_en;
        w       = mem_w_en;
        rd      = mem_r_en & !mem_w_en;
        lo      = lo_of(alu_res);
        hi      = lo | 18'd1;
        m_ready = !op || (k == AC - 1);
        e_addr  = m_addr_last;
        e_we    = 1'b1;
        e_oe    = 1'b0;
        e_dq    = '0;
        if (op && k < 2) begin
            e_addr = (k == 0) ? lo : hi;
            e_we   = !w;
            e_oe   = w;
            if (w)
                e_dq = (k == 0) ? val_rm[15:0]
                                : val_rm[31:16];
        end
        s_ready  = ready;
        s_addr   = sram_addr;
        s_dq     = sram_dq_out;
        s_we     = sram_we_n;
        s3_ready = t_ready;
        chk("ready", ready, m_ready);
        chk("sram_addr", sram_addr, e_addr);
        chk("sram_we_n", sram_we_n, e_we);
        chk("sram_dq_oe", sram_dq_oe, e_oe);
        chk("sram_dq_out", sram_dq_out, e_dq);
        @(posedge clk);
        #1;
        if (!s_we)
            dev[s_addr[9:0]] = s_dq;
        if (m_ready) begin
            m_wb   = wb_en_in;
            m_mr   = rd;
            m_alu  = alu_res;
            m_dest = dest_in;
            m_data = {m_hi, m_lo};
        end else begin
            m_wb = 1'b0;
            m_mr = 1'b0;
        end
        if (op && k < 2) begin
            m_addr_last = e_addr;
            if (w)
                refm[e_addr[9:0]] = e_dq;
            else if (k == 0)
                m_lo = refm[lo[9:0]];
            else
                m_hi = refm[hi[9:0]];
        end
        k = (!op || k == AC - 1) ? 0 : k + 1;
        chk("wb_en_out", wb_en_out, m_wb);
        chk("mem_r_en_out", mem_r_en_out, m_mr);
        chk("alu_res_out", alu_res_out, m_alu);
        chk("mem_data", mem_data, m_data);
        chk("dest_out", dest_out, m_dest);
    endtask

    task automatic new_instr();
        int          kind;
        logic [31:0] a;
        kind = $urandom_range(0, 99);
        a    = BASE + $urandom_range(0, 511) * 4
             + $urandom_range(0, 3);
        if (kind < 40)
            set_in(1'($urandom), 0, 0, $urandom,
                   $urandom, 4'($urandom));
        else if (kind < 70)
            set_in(1'($urandom), 1, 0, a,
                   $urandom, 4'($urandom));
        else if (kind < 95)
            set_in(1'($urandom), 0, 1, a,
                   $urandom, 4'($urandom));
        else
            set_in(1'($urandom), 1, 1, a,
                   $urandom, 4'($urandom));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rp;
        for (int i = 0; i < 1024; i++) begin
            logic [15:0] v;
            v       = 16'($urandom);
            dev[i]  = v;
            refm[i] = v;
        end
        model_reset();
        t_wb  = 1'b1;
        t_r   = 1'b1;
        t_w   = 1'b0;
        t_alu = 32'd1032;
        t_val = '0;
        t_dest = 4'd6;

        // reset held with an op pending
        rest = 1'b0;
        set_in(1, 0, 1, 32'd1032, 32'h1234_5678, 4'd2);
        #22;
        reset_checks("rst_hold");
        set_in(0, 0, 0, '0, '0, '0);
        t_r = 1'b0;
        @(posedge clk);
        #1;
        rest = 1'b1;
        step();
        chk("rel_ready", s_ready, 1);
        chk("rel_we_n", s_we, 1);

        // store then load, back to back
        rp = 0;
        set_in(0, 0, 1, 32'd1032, 32'hDEAD_BEEF, 4'd5);
        for (int i = 0; i < 6; i++) begin
            step();
            rp += int'(s_ready);
            chk("st_ready", s_ready, i == 5);
            chk("st_wb_out", wb_en_out, 0);
            if (i == 0) begin
                chk("st_addr0", s_addr, 18'd4);
                chk("st_dq0", s_dq, 16'hBEEF);
                chk("st_we0", s_we, 0);
            end
            if (i == 1) begin
                chk("st_addr1", s_addr, 18'd5);
                chk("st_dq1", s_dq, 16'hDEAD);
                chk("st_we1", s_we, 0);
            end
        end
        set_in(1, 1, 0, 32'd1032, '0, 4'd7);
        for (int i = 0; i < 6; i++) begin
            step();
            rp += int'(s_ready);
            chk("ld_ready", s_ready, i == 5);
            chk("ld_wb_out", wb_en_out, i == 5);
        end
        chk("ld_data", mem_data, 32'hDEAD_BEEF);
        chk("ld_mr", mem_r_en_out, 1);
        chk("ld_dest", dest_out, 7);
        chk("b2b_pulses", rp, 2);

        // plain ALU op
        set_in(1, 0, 0, 32'h55, '0, 4'd3);
        step();
        chk("alu_ready", s_ready, 1);
        chk("alu_res", alu_res_out, 32'h55);
        chk("alu_dest", dest_out, 3);
        chk("alu_wb", wb_en_out, 1);

        // op withdrawn during the high half
        set_in(1, 1, 0, 32'd1040, '0, 4'd9);
        step();
        set_in(1, 0, 0, 32'h77, '0, 4'd2);
        step();
        chk("ab_ready", s_ready, 1);
        chk("ab_we_n", s_we, 1);
        chk("ab_mr", mem_r_en_out, 0);
        chk("ab_alu", alu_res_out, 32'h77);
        set_in(1, 1, 0, 32'd1040, '0, 4'd9);
        for (int i = 0; i < 6; i++) begin
            step();
            if (i == 0)
                chk("ab_restart_addr", s_addr, 18'd8);
            chk("ab_restart_ready", s_ready, i == 5);
        end

        // reset while waiting
        set_in(1, 1, 0, 32'd1044, '0, 4'd4);
        step();
        step();
        step();
        #2;
        rest = 1'b0;
        #1;
        reset_checks("rst_wait");
        model_reset();
        set_in(0, 0, 0, '0, '0, '0);
        @(posedge clk);
        #1;
        rest = 1'b1;

        // three-cycle variant
        t_wb   = 1'b1;
        t_r    = 1'b1;
        t_alu  = 32'd1032;
        t_dest = 4'd6;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ac3_ready", s3_ready, i == 2);
        end
        chk("ac3_data", t_data, 32'hDEAD_BEEF);
        chk("ac3_mr", t_mr_out, 1);
        chk("ac3_wb", t_wb_out, 1);
        t_r  = 1'b0;
        t_wb = 1'b0;

        // random traffic
        new_instr();
        for (int c = 0; c < 2000; c++) begin
            step();
            if (m_ready)
                new_instr();
            else if ($urandom_range(0, 99) < 3)
                set_in(1'($urandom), 0, 0, $urandom,
                       $urandom, 4'($urandom));
        end

        $display(
          "End of test - %0d assertions evaluated, %0d failures",
          n_checks, n_fail);
        $finish;
    end

endmodule
